// File: rtl/reg_pkg.sv
// Shared register mask type and mask decode for the register access blocks.
package reg_pkg;

  typedef enum logic [1:0] {LS8, LS16, LS27, LS32} reg_mask_e;

  // Anything that is not a known field width behaves as a full-width access.
  function automatic logic [31:0] mask_of(input reg_mask_e m);
    logic [31:0] r;
    case (m)
      LS8:     r = 32'h0000_00FF;
      LS16:    r = 32'h0000_FFFF;
      LS27:    r = 32'h07FF_FFFF;
      LS32:    r = 32'hFFFF_FFFF;
      default: r = 32'hFFFF_FFFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/masked_reg_writer.sv
// Register file with a 2-stage masked read-modify-write pipeline and a filtered read port.
// Optional macro MASKED_REG_WRITER_CLEAR_UPPER_EN: writes zero the bits outside the mask.
module masked_reg_writer
  import reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  reg_mask_e         wr_mask,
  output logic              wr_done,
  input  logic [ADDR_W-1:0] rd_addr,
  input  reg_mask_e         rd_mask,
  output logic [31:0]       rd_data
);

  logic [31:0]       regs_q [NUM_REGS];

  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [31:0]       s1_data_q;
  reg_mask_e         s1_mask_q;

  logic              s2_valid_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic [31:0]       s2_data_q;

  logic              done_q;
  logic [31:0]       rd_data_q;

  logic              accept;
  logic [31:0]       s1_merged;
  logic [31:0]       rd_value;

  assign wr_ready = rst_n & ~hold;
  assign accept   = wr_valid & wr_ready;

  always_comb begin
    s1_merged = '0;
`ifdef MASKED_REG_WRITER_CLEAR_UPPER_EN
    s1_merged = s1_data_q & mask_of(s1_mask_q);
`else
    // The S2 entry is newer than the regfile for the same address.
    if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
      s1_merged = (s2_data_q & ~mask_of(s1_mask_q)) | (s1_data_q & mask_of(s1_mask_q));
    end else begin
      s1_merged = (regs_q[s1_addr_q] & ~mask_of(s1_mask_q)) | (s1_data_q & mask_of(s1_mask_q));
    end
`endif
  end

  always_comb begin
    rd_value = regs_q[rd_addr];
    if (s1_valid_q && (s1_addr_q == rd_addr)) begin
      rd_value = s1_merged;
    end else if (s2_valid_q && (s2_addr_q == rd_addr)) begin
      rd_value = s2_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_mask_q  <= LS32;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= wr_addr;
        s1_data_q <= wr_data;
        s1_mask_q <= wr_mask;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_addr_q <= s1_addr_q;
        s2_data_q <= s1_merged;
      end
      if (s2_valid_q) begin
        regs_q[s2_addr_q] <= s2_data_q;
      end
      done_q    <= s2_valid_q;
      rd_data_q <= rd_value & mask_of(rd_mask);
    end
  end

  assign wr_done = done_q;
  assign rd_data = rd_data_q;

endmodule
